// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO; 8N1 framing, LSB first.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int BAUD_PER = 10416,
    parameter int FIFO_AW  = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW = $clog2(BAUD_PER);
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_PER - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         head;
    logic               push;
    logic               pop;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          tx_q;
    logic          tx_nxt;
    logic          bit_end;
    logic          can_pop;
    logic          load;
`ifdef UART_TX_PARITY_EN
    logic          par;
    logic          par_nxt;
`endif

    assign head       = mem[rd_ptr];
    assign data_ready = (count < DEPTH_C);
    assign push       = data_valid && data_ready;
    assign fifo_count = count;
    assign busy       = (state != S_IDLE);
    assign tx         = tx_q;
    assign bit_end    = (baud == BAUD_MAX);
    assign can_pop    = en && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        tx_nxt    = tx_q;
        shift_nxt = shift;
        bit_nxt   = bit_cnt;
        baud_nxt  = bit_end ? '0 : baud + 1'b1;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par;
`endif
        unique case (state)
            S_IDLE: begin
                baud_nxt = '0;
                if (can_pop) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    tx_nxt    = shift[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = par;
`else
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (can_pop) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // back-to-back frames reuse the idle load path straight from stop
        if (load) begin
            pop       = 1'b1;
            state_nxt = S_START;
            tx_nxt    = 1'b0;
            shift_nxt = head;
            baud_nxt  = '0;
            bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^head;
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            baud    <= baud_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            tx_q    <= tx_nxt;
`ifdef UART_TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: per-cycle frame-timeline model plus directed
// literal checks. Honors UART_TX_PARITY_EN like the design.
module tb_uart_tx_fifo;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    int pat[NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int NB = 10;
    int pat[NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    localparam int FC = NB * B;

    logic       clk;
    logic       nrst;
    logic       en;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.BAUD_PER(B), .FIFO_AW(3)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a frame is a fixed timeline of NB bits, B cycles each.
    logic [7:0] q[$];
    logic [7:0] cur;
    int         k;
    bit         mb;
    bit         rdy;

    function automatic logic bitval(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q.delete();
            mb = 0;
            k  = 0;
        end else begin
            rdy = (q.size() < 8);
            if (mb) begin
                k++;
                if (k == FC) mb = 0;
            end
            if (!mb && en && q.size() > 0) begin
                cur = q.pop_front();
                k   = 0;
                mb  = 1;
            end
            if (data_valid && rdy) q.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        check("tx", tx, mb ? bitval(cur, k / B) : 1'b1);
        check("busy", busy, mb);
        check("fifo_count", fifo_count, q.size());
        check("data_ready", data_ready, q.size() < 8);
    end

    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (busy) begin
            run++;
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(input int max, input bit need_empty);
        int n = 0;
        while ((busy || (need_empty && fifo_count != 0)) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (busy || (need_empty && fifo_count != 0)) begin
            errors++;
            $display("FAIL wait_idle: still busy=%0d count=%0d after %0d",
                     busy, fifo_count, max);
        end
    endtask

    task automatic push(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros;
        nrst       = 1'b0;
        en         = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        tick(2);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", data_ready, 1);
        nrst = 1'b1;
        tick(2);

        // single 0xA5 frame, bit by bit
        en = 1'b1;
        push(8'hA5);
        check("a5_pre_tx", tx, 1);
        check("a5_pre_count", fifo_count, 1);
        tick();
        check("a5_start_busy", busy, 1);
        for (int j = 0; j < NB; j++) begin
            check($sformatf("a5_bit%0d", j), tx, pat[j]);
            if (j == NB - 1) begin
                tick(3);
                check("a5_busy_last", busy, 1);
                tick();
            end else begin
                tick(4);
            end
        end
        check("a5_busy_end", busy, 0);
        check("a5_tx_end", tx, 1);
        tick(3);

`ifdef UART_TX_PARITY_EN
        data_valid = 1'b1;
        data_in    = 8'h55;
        tick();
        data_in    = 8'h07;
        tick();
        data_valid = 1'b0;
        tick(36);
        check("par_55", tx, 0);
        tick(44);
        check("par_07", tx, 1);
        wait_idle(200, 1);
        tick(2);
`endif

        // overflow: leader frame holds the line, then 9 pushes
        push(8'h3C);
        tick(2);
        data_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data_in = 8'(8'h10 + i * 8'h11);
            tick();
        end
        data_valid = 1'b0;
        check("ovf_count", fifo_count, 8);
        check("ovf_ready", data_ready, 0);
        wait_idle(2000, 1);
        tick();
        check("ovf_run", last_run, 9 * FC);
        tick(3);

        // en low: bytes queue up, nothing sent
        en = 1'b0;
        push(8'h01);
        push(8'h80);
        push(8'hC3);
        tick(5);
        check("hold_tx", tx, 1);
        check("hold_count", fifo_count, 3);
        check("hold_busy", busy, 0);
        en = 1'b1;
        wait_idle(1000, 1);
        tick();
        check("drain_run", last_run, 3 * FC);
        check("drain_count", fifo_count, 0);
        tick(3);

        // en dropped mid-frame: frame completes, next byte waits
        push(8'h81);
        tick(10);
        en = 1'b0;
        push(8'h42);
        wait_idle(200, 0);
        tick();
        check("endrop_run", last_run, FC);
        check("endrop_count", fifo_count, 1);
        tick(5);
        check("endrop_idle_tx", tx, 1);
        en = 1'b1;
        wait_idle(200, 1);
        tick(3);

        // async reset mid data bit with two bytes queued
        data_valid = 1'b1;
        data_in    = 8'hF0;
        tick();
        data_in    = 8'h0F;
        tick();
        data_in    = 8'h99;
        tick();
        data_valid = 1'b0;
        tick(8);
        check("pre_rst_count", fifo_count, 2);
        nrst = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_count", fifo_count, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", data_ready, 1);
        #3;
        nrst = 1'b1;
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx == 1'b0) zeros++;
        end
        check("post_rst_zeros", zeros, 0);
        check("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
